// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
// Mode encodings select wrap or saturate behaviour at the range ends.
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Load values beyond the count range are clamped to the top of the range.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [31:0] modulus);
    logic [31:0] lim;
    lim = modulus - 32'd1;
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/n_bit_mod_counter_tc.sv
// Terminal-count detector: flags when the next count step in the current
// direction would cross a range end (top when counting up, zero when down).
module n_bit_mod_counter_tc #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  output logic             at_max_o,
  output logic             at_min_o
);

  // Compare one bit wider so MODULUS = 2^WIDTH needs no special case.
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0] q_ext;

  assign q_ext    = {1'b0, q_i};
  assign at_max_o = up_i & (q_ext == MAX_EXT);
  assign at_min_o = ~up_i & (q_ext == '0);

endmodule

// File: rtl/n_bit_mod_counter.sv
// Modulo-N up/down counter with load, clear, wrap/saturate mode,
// combinational terminal count and a sticky overflow flag.
module n_bit_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clear,
  output logic [WIDTH-1:0] Q,
  output logic             z,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_min;

  n_bit_mod_counter_tc #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc (
    .q_i      (q_q),
    .up_i     (up),
    .at_max_o (at_max),
    .at_min_o (at_min)
  );

  // z marks the cycle whose edge will wrap or saturate.
  assign z = x & ~load & ~clear & (at_max | at_min);

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (clear) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      q_d = WIDTH'(clamp_load(32'(d), 32'(MODULUS)));
    end else if (x) begin
      if (at_max) begin
        ovf_d = 1'b1;
        q_d   = (SATURATE == MODE_SAT) ? q_q : '0;
      end else if (at_min) begin
        ovf_d = 1'b1;
        q_d   = (SATURATE == MODE_SAT) ? q_q : MAX_Q;
      end else if (up) begin
        q_d = q_q + ONE;
      end else begin
        q_d = q_q - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign ovf = ovf_q;

endmodule
